conv3x3_stream_ctrl: RTL and testbench

Streaming controller that sequences the 3x3 multiply-add datapath over one raster-order image frame. It buffers two image lines and a 3x3 sliding window, presents the packed window and latched weights to an externally instantiated 3x3 multiply-add, and registers each result onto a valid/ready output stream. It covers only valid (unpadded) positions, giving (IMG_W-2)*(IMG_H-2) results per frame, and sits between the pixel source and the feature-map writer.

---
 rtl/conv3x3_stream_ctrl.sv | 147 ++++++++++++++
 tb/tb_conv3x3_stream_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream_ctrl.sv
// Frame sequencer for an external 3x3 multiply-add: two line buffers, a 3x3
// sliding window, and a two-stage valid/ready pipeline onto the result stream.
module conv3x3_stream_ctrl #(
    parameter int I_BIT_WIDTH = 8,
    parameter int O_BIT_WIDTH = 32,
    parameter int K_SIZE      = 3,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [I_BIT_WIDTH*K_SIZE*K_SIZE-1:0] weights_in,
    input  logic [I_BIT_WIDTH-1:0]         in_pixel,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [I_BIT_WIDTH*K_SIZE*K_SIZE-1:0] win_data,
    output logic [I_BIT_WIDTH*K_SIZE*K_SIZE-1:0] win_weights,
    input  logic [O_BIT_WIDTH-1:0]         conv_in,
    output logic [O_BIT_WIDTH-1:0]         out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done
);
    localparam int WIN_N = K_SIZE * K_SIZE;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int PW    = $clog2(IMG_W * IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [PW-1:0] PIX_LAST = PW'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
    state_t state_reg, state_next;

    logic [CW-1:0]                col_reg;
    logic [RW-1:0]                row_reg;
    logic [PW-1:0]                pix_reg;
    logic [I_BIT_WIDTH*WIN_N-1:0] weights_reg;
    logic [I_BIT_WIDTH-1:0]       win_reg      [WIN_N];
    logic [I_BIT_WIDTH-1:0]       linebuf0_reg [IMG_W];
    logic [I_BIT_WIDTH-1:0]       linebuf1_reg [IMG_W];
    logic                         win_valid_reg;
    logic                         out_valid_reg;
    logic [O_BIT_WIDTH-1:0]       out_data_reg;

    logic adv, accept, pos_ok, start_ok;

    // The whole pipeline freezes only when a result is waiting and not taken.
    assign adv      = !(out_valid_reg && !out_ready);
    assign in_ready = (state_reg == ST_RUN) && adv;
    assign accept   = in_valid && in_ready;
    assign pos_ok   = (row_reg >= ROW_TWO) && (col_reg >= COL_TWO);
    assign start_ok = (state_reg == ST_IDLE) && start;

    assign out_data    = out_data_reg;
    assign out_valid   = out_valid_reg;
    assign win_weights = weights_reg;

    // Window element index is 3*row + column, oldest row/column first.
    genvar gi;
    generate
        for (gi = 0; gi < WIN_N; gi++) begin : g_win
            assign win_data[I_BIT_WIDTH*gi +: I_BIT_WIDTH] = win_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                linebuf0_reg[i] <= '0;
                linebuf1_reg[i] <= '0;
            end
        end else if (accept) begin
            linebuf1_reg[col_reg] <= linebuf0_reg[col_reg];
            linebuf0_reg[col_reg] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN_N; i++) win_reg[i] <= '0;
        end else if (accept) begin
            for (int x = 0; x < K_SIZE; x++) begin
                win_reg[K_SIZE*x]     <= win_reg[K_SIZE*x + 1];
                win_reg[K_SIZE*x + 1] <= win_reg[K_SIZE*x + 2];
            end
            win_reg[2] <= linebuf1_reg[col_reg];
            win_reg[5] <= linebuf0_reg[col_reg];
            win_reg[8] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            col_reg       <= '0;
            row_reg       <= '0;
            pix_reg       <= '0;
            weights_reg   <= '0;
            win_valid_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                weights_reg <= weights_in;
                col_reg     <= '0;
                row_reg     <= '0;
                pix_reg     <= '0;
            end else if (accept) begin
                pix_reg <= pix_reg + PW'(1);
                if (col_reg == COL_LAST) begin
                    col_reg <= '0;
                    row_reg <= row_reg + RW'(1);
                end else begin
                    col_reg <= col_reg + CW'(1);
                end
            end
            if (adv) begin
                out_valid_reg <= win_valid_reg;
                if (win_valid_reg) out_data_reg <= conv_in;
                win_valid_reg <= accept && pos_ok;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != ST_IDLE);
        done       = 1'b0;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (accept && pix_reg == PIX_LAST) state_next = ST_DRAIN;
            // Leave once the last result is gone or is being taken this cycle.
            ST_DRAIN: if (!win_valid_reg && (!out_valid_reg || out_ready)) state_next = ST_DONE;
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_conv3x3_stream_ctrl.sv
// Bench for conv3x3_stream_ctrl on a 4x4 frame: behavioural multiply-add,
// convolution reference computed directly from the frame array.
module tb_conv3x3_stream_ctrl;
    localparam int W = 4;
    localparam int H = 4;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [71:0] weights_in = '0;
    logic [7:0]  in_pixel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [71:0] win_data;
    logic [71:0] win_weights;
    logic signed [31:0] conv_in;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;

    conv3x3_stream_ctrl #(
        .I_BIT_WIDTH(8), .O_BIT_WIDTH(32), .K_SIZE(3), .IMG_W(W), .IMG_H(H)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .weights_in(weights_in),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
        .win_data(win_data), .win_weights(win_weights), .conv_in(conv_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // External multiply-add stand-in.
    always_comb begin
        conv_in = '0;
        for (int i = 0; i < 9; i++)
            conv_in = conv_in + 32'($signed(win_data[i*8 +: 8])) * 32'($signed(win_weights[i*8 +: 8]));
    end

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    logic signed [7:0] img [NPIX];
    logic signed [7:0] wts [9];
    int got_q [$];
    int exp_q [$];
    int done_cnt;
    int first_ov_cyc;
    int acc_cyc [NPIX];
    bit bp_bad_ready, bp_bad_data, bp_bad_valid, bp_started;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (out_valid && out_ready) got_q.push_back(int'($signed(out_data)));
            if (done) done_cnt++;
        end
    end

    function automatic logic [71:0] pack_w();
        logic [71:0] p;
        for (int i = 0; i < 9; i++) p[i*8 +: 8] = wts[i];
        return p;
    endfunction

    task automatic build_exp();
        int s;
        exp_q.delete();
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++) begin
                s = 0;
                for (int x = 0; x < 3; x++)
                    for (int y = 0; y < 3; y++)
                        s += int'(img[(r - 2 + x) * W + (c - 2 + y)]) * int'(wts[3*x + y]);
                exp_q.push_back(s);
            end
    endtask

    task automatic run_frame(input int gap_pct, input int stall_pct, input bit bp_hold,
                             input int mid_start_at, input int rst_at, output bit timed_out);
        int idx, hold, budget, post;
        bit mid_done;
        logic [31:0] bp_data;
        got_q.delete();
        done_cnt = 0;
        first_ov_cyc = -1;
        bp_bad_ready = 0; bp_bad_data = 0; bp_bad_valid = 0; bp_started = 0;
        idx = 0; hold = 0; budget = 0; post = 0; mid_done = 0; timed_out = 0;
        bp_data = '0;
        @(negedge clk);
        start = 1'b1; weights_in = pack_w(); in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        forever begin
            if (bp_hold && !bp_started && out_valid) begin
                bp_started = 1; hold = 5; bp_data = out_data;
            end
            in_valid = (idx < NPIX) && ($urandom_range(99) >= 32'(gap_pct));
            in_pixel = (idx < NPIX) ? img[idx] : 8'($urandom_range(255));
            out_ready = (hold > 0) ? 1'b0 : ($urandom_range(99) >= 32'(stall_pct));
            if (idx == mid_start_at && !mid_done) begin
                start = 1'b1; mid_done = 1;
                weights_in = {8'($urandom_range(255)), $urandom, $urandom};
            end else begin
                start = 1'b0; weights_in = pack_w();
            end
            #1;
            if (hold > 0) begin
                if (in_ready) bp_bad_ready = 1;
                if (out_data !== bp_data) bp_bad_data = 1;
                if (!out_valid) bp_bad_valid = 1;
                hold--;
            end
            if (in_valid && in_ready) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx == rst_at) begin
                    @(posedge clk); #1;
                    in_valid = 1'b0; start = 1'b0;
                    return;
                end
            end
            if (done_cnt > 0) post++;
            if (post > 3) break;
            budget++;
            if (budget > 2000) begin timed_out = 1; break; end
            @(negedge clk);
        end
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        nvec++; if (out_data !== 32'd0) begin nerr++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        nvec++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL reset_busy_done: got %0b%0b expected 00", busy, done); end
        nvec++; if (win_data !== 72'd0 || win_weights !== 72'd0) begin nerr++; $display("FAIL reset_window: got %0h/%0h expected 0", win_data, win_weights); end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: checked idle outputs");
    endtask

    task automatic check_results(input string name, input bit timed_out);
        nvec++;
        if (timed_out) begin nerr++; $display("FAIL %s_timeout: frame did not finish within budget", name); end
        nvec++;
        if (got_q.size() != exp_q.size()) begin
            nerr++; $display("FAIL %s_count: got %0d results expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            nvec++;
            if (got_q[i] != exp_q[i]) begin
                nerr++; $display("FAIL %s_result[%0d]: got %0d expected %0d", name, i, got_q[i], exp_q[i]);
            end
        end
        nvec++;
        if (done_cnt != 1) begin nerr++; $display("FAIL %s_done: got %0d pulses expected 1", name, done_cnt); end
        nvec++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL %s_busy_after: got %0b expected 0", name, busy); end
        $display("%s: %0d results, %0d done pulses", name, got_q.size(), done_cnt);
    endtask

    task automatic test_ones();
        bit to;
        for (int i = 0; i < NPIX; i++) img[i] = 8'sd1;
        for (int i = 0; i < 9; i++) wts[i] = 8'sd1;
        build_exp();
        run_frame(0, 0, 0, -1, -1, to);
        check_results("ones", to);
        foreach (got_q[i]) begin
            nvec++;
            if (got_q[i] != 9) begin nerr++; $display("FAIL ones_value[%0d]: got %0d expected 9", i, got_q[i]); end
        end
    endtask

    task automatic test_ramp();
        bit to;
        int ramp_exp [4] = '{5, 6, 9, 10};
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r*W + c] = 8'(4*r + c);
        for (int i = 0; i < 9; i++) wts[i] = (i == 4) ? 8'sd1 : 8'sd0;
        build_exp();
        run_frame(0, 0, 0, -1, -1, to);
        check_results("ramp", to);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            nvec++;
            if (got_q[i] != ramp_exp[i]) begin nerr++; $display("FAIL ramp_value[%0d]: got %0d expected %0d", i, got_q[i], ramp_exp[i]); end
        end
        nvec++;
        if (first_ov_cyc != acc_cyc[10] + 2)
            begin nerr++; $display("FAIL ramp_latency: got cycle %0d expected %0d", first_ov_cyc, acc_cyc[10] + 2); end
    endtask

    task automatic test_signed();
        bit to;
        for (int i = 0; i < NPIX; i++) img[i] = -8'sd128;
        for (int i = 0; i < 9; i++) wts[i] = 8'sd127;
        build_exp();
        run_frame(30, 0, 0, -1, -1, to);
        check_results("signed", to);
        foreach (got_q[i]) begin
            nvec++;
            if (got_q[i] != -146304) begin nerr++; $display("FAIL signed_value[%0d]: got %0d expected -146304", i, got_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(255));
        for (int i = 0; i < 9; i++) wts[i] = 8'($urandom_range(255));
        build_exp();
        run_frame(0, 0, 1, -1, -1, to);
        check_results("backpressure", to);
        nvec++; if (!bp_started) begin nerr++; $display("FAIL bp_started: got 0 expected 1"); end
        nvec++; if (bp_bad_ready) begin nerr++; $display("FAIL bp_in_ready: got 1 during stall expected 0"); end
        nvec++; if (bp_bad_data) begin nerr++; $display("FAIL bp_data_stable: got change during stall expected stable"); end
        nvec++; if (bp_bad_valid) begin nerr++; $display("FAIL bp_out_valid: got 0 during stall expected 1"); end
    endtask

    task automatic test_reset_midframe();
        bit to;
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(255));
        for (int i = 0; i < 9; i++) wts[i] = 8'($urandom_range(255));
        run_frame(0, 0, 0, -1, 7, to);
        rst = 1'b1;
        #1;
        nvec++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0)
            begin nerr++; $display("FAIL midrst_state: got busy=%0b in_ready=%0b out_valid=%0b expected 000", busy, in_ready, out_valid); end
        nvec++; if (win_weights !== 72'd0) begin nerr++; $display("FAIL midrst_weights: got %0h expected 0", win_weights); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NPIX; i++) img[i] = 8'sd1;
        for (int i = 0; i < 9; i++) wts[i] = 8'sd1;
        build_exp();
        run_frame(0, 0, 0, -1, -1, to);
        check_results("reset_midframe", to);
    endtask

    task automatic test_start_during_run();
        bit to;
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(255));
        for (int i = 0; i < 9; i++) wts[i] = 8'($urandom_range(255));
        build_exp();
        run_frame(10, 10, 0, 5, -1, to);
        check_results("start_during_run", to);
        nvec++;
        if (win_weights !== pack_w()) begin nerr++; $display("FAIL start_run_weights: got %0h expected %0h", win_weights, pack_w()); end
    endtask

    task automatic test_random();
        bit to;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(255));
            for (int i = 0; i < 9; i++) wts[i] = 8'($urandom_range(255));
            build_exp();
            run_frame(30, 30, 0, -1, -1, to);
            check_results("random", to);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_ramp();
        test_signed();
        test_backpressure();
        test_reset_midframe();
        test_start_during_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
